// File: rtl/nn_bram_pkg.sv
// Shared definitions for the 28-bank weight BRAM array: geometry, loader
// FSM encoding, the registered write bundle and a bank one-hot helper.
// Also used by bram_array and the inference address sequencer.
package nn_bram_pkg;

    localparam int unsigned NUM_BANKS   = 28;
    localparam int unsigned DEPTH       = 785;
    localparam int unsigned ADDR_W      = 11;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned BANK_W      = 5;
    localparam int unsigned TOTAL_WORDS = NUM_BANKS * DEPTH;

    // Loader FSM encoding
    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_LOAD_ENC   = 2'd1;
    localparam logic [1:0] ST_FINISH_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_LOAD   = ST_LOAD_ENC,
        ST_FINISH = ST_FINISH_ENC
    } load_state_e;

    // One BRAM write as presented on the array pins
    typedef struct packed {
        logic [NUM_BANKS-1:0] we;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    di;
    } bram_wr_t;

    // One-hot bank select for the per-bank write-enable vector
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_W-1:0] bank);
        return NUM_BANKS'(1) << bank;
    endfunction

endpackage

// File: rtl/bram_array_loader_if.sv
// Byte stream in / BRAM write port out for bram_array_loader.
// master: loader side (consumes stream, drives BRAM pins).
// slave : environment side (drives stream, observes BRAM pins).
interface bram_array_loader_if;
    import nn_bram_pkg::*;

    logic [DATA_W-1:0]    S_DATA;
    logic                 S_VALID;
    logic                 S_READY;
    logic                 BRAM_EN;
    logic [NUM_BANKS-1:0] BRAM_WE;
    logic [ADDR_W-1:0]    BRAM_ADDR;
    logic [DATA_W-1:0]    BRAM_DI;

    modport master (
        input  S_DATA, S_VALID,
        output S_READY, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI
    );

    modport slave (
        output S_DATA, S_VALID,
        input  S_READY, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI
    );

endinterface

// File: rtl/bram_addr_counter.sv
// Two-level bank-major address counter: addr runs 0..DEPTH-1, then wraps
// and bumps bank. last_c flags the final word of the final bank; both
// counters wrap to zero after it so the block can cycle for read-side use.
// Ports: clk, rst_n (sync, active-low), clear, advance -> addr, bank, last_c.
module bram_addr_counter
    import nn_bram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic [BANK_W-1:0] bank,
    output logic              last_c
);

    logic addr_wrap_c;

    assign addr_wrap_c = (addr == ADDR_W'(DEPTH - 1));
    assign last_c      = addr_wrap_c && (bank == BANK_W'(NUM_BANKS - 1));

    // Counter update; clear has priority over advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= '0;
            bank <= '0;
        end else if (clear) begin
            addr <= '0;
            bank <= '0;
        end else if (advance) begin
            if (addr_wrap_c) begin
                addr <= '0;
                bank <= last_c ? '0 : bank + BANK_W'(1);
            end else begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/bram_array_loader.sv
// Fills the 28-bank weight BRAM array from an 8-bit byte stream, bank-major,
// 785 words per bank (784 weights then bias). One write per accepted byte,
// one cycle after the handshake.
// Ports: CLK, RST_N (sync, active-low), START, ABORT, bus (stream + BRAM
// write pins, master side), BUSY, DONE, BANK_IDX (bank being filled).
module bram_array_loader
    import nn_bram_pkg::*;
(
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       START,
    input  logic                       ABORT,
    bram_array_loader_if.master        bus,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [BANK_W-1:0]          BANK_IDX
);

    load_state_e       state, state_d;
    bram_wr_t          wr_q, wr_d;
    logic              en_q, en_d;
    logic              busy_d, done_d;
    logic              ready_c, hs_c, clear_c, last_c;
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] bank;

    // Ready is combinational so ABORT can block the same-cycle byte
    assign ready_c = (state == ST_LOAD) && !ABORT;
    assign hs_c    = ready_c && bus.S_VALID;
    assign clear_c = (state == ST_IDLE) && START;

    bram_addr_counter u_addr_counter (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clear   (clear_c),
        .advance (hs_c),
        .addr    (addr),
        .bank    (bank),
        .last_c  (last_c)
    );

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            en_q  <= 1'b0;
            wr_q  <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_d;
            en_q  <= en_d;
            wr_q  <= wr_d;
            BUSY  <= busy_d;
            DONE  <= done_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d  = state;
        en_d     = 1'b0;
        wr_d     = wr_q;
        wr_d.we  = '0;
        busy_d   = BUSY;
        done_d   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (hs_c) begin
                    en_d      = 1'b1;
                    wr_d.we   = bank_onehot(bank);
                    wr_d.addr = addr;
                    wr_d.di   = bus.S_DATA;
                    if (last_c) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.S_READY   = ready_c;
    assign bus.BRAM_EN   = en_q;
    assign bus.BRAM_WE   = wr_q.we;
    assign bus.BRAM_ADDR = wr_q.addr;
    assign bus.BRAM_DI   = wr_q.di;
    assign BANK_IDX      = bank;

endmodule

// File: tb/tb_bram_array_loader.sv
// Self-checking bench for bram_array_loader: a cycle model predicts S_READY,
// BUSY and DONE; every predicted BRAM write is queued at the handshake and
// compared against the pins one cycle later.
module tb_bram_array_loader;
    import nn_bram_pkg::*;

    typedef struct {
        logic [NUM_BANKS-1:0] we;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    di;
    } exp_wr_t;

    localparam int M_IDLE   = 0;
    localparam int M_LOAD   = 1;
    localparam int M_FINISH = 2;

    logic              CLK   = 1'b0;
    logic              RST_N = 1'b0;
    logic              START = 1'b0;
    logic              ABORT = 1'b0;
    logic              BUSY;
    logic              DONE;
    logic [BANK_W-1:0] BANK_IDX;

    bram_array_loader_if bus_if ();

    bram_array_loader dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .ABORT    (ABORT),
        .bus      (bus_if),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .BANK_IDX (BANK_IDX)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    exp_wr_t sb_q[$];

    // Reference model state
    int                   m_state = M_IDLE;
    int                   m_bank  = 0;
    int                   m_addr  = 0;
    logic                 m_busy  = 1'b0;
    logic                 m_done  = 1'b0;
    logic                 m_en    = 1'b0;
    logic [NUM_BANKS-1:0] m_we    = '0;
    logic [ADDR_W-1:0]    m_addr_o = '0;
    logic [DATA_W-1:0]    m_di    = '0;
    logic                 m_known = 1'b0;

    // Observed-write bookkeeping
    int                   cyc_n      = 0;
    int                   wr_count   = 0;
    int                   done_count = 0;
    int                   done_cyc   = 0;
    logic [NUM_BANKS-1:0] first_we, w785_we, last_we;
    logic [ADDR_W-1:0]    first_addr, w785_addr, last_addr;
    logic [DATA_W-1:0]    last_di;

    function automatic logic [DATA_W-1:0] pattern(input int bank, input int addr);
        return DATA_W'((bank + addr) & 255);
    endfunction

    // One clock: drive inputs after a falling edge, predict, check after the next falling edge
    task automatic step(input logic rst_n, input logic start, input logic abort,
                        input logic valid, input logic [DATA_W-1:0] data);
        logic    exp_ready;
        logic    hs;
        exp_wr_t w;
        RST_N          = rst_n;
        START          = start;
        ABORT          = abort;
        bus_if.S_VALID = valid;
        bus_if.S_DATA  = data;
        #1;
        exp_ready = (m_state == M_LOAD) && !abort;
        if (m_known) begin
            n_checks++;
            if (bus_if.S_READY !== exp_ready) begin
                n_fail++;
                $display("FAIL s_ready cyc=%0d got %b expected %b", cyc_n, bus_if.S_READY, exp_ready);
            end
        end
        hs     = exp_ready && valid;
        m_done = 1'b0;
        if (!rst_n) begin
            m_state = M_IDLE;
            m_bank  = 0;
            m_addr  = 0;
            m_busy  = 1'b0;
            sb_q.delete();
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (start) begin
                        m_state = M_LOAD;
                        m_bank  = 0;
                        m_addr  = 0;
                        m_busy  = 1'b1;
                    end
                end
                M_LOAD: begin
                    if (abort) begin
                        m_state = M_IDLE;
                        m_busy  = 1'b0;
                    end else if (hs) begin
                        w.we   = NUM_BANKS'(1) << m_bank;
                        w.addr = ADDR_W'(m_addr);
                        w.di   = data;
                        sb_q.push_back(w);
                        if (m_addr == DEPTH - 1) begin
                            m_addr = 0;
                            if (m_bank == NUM_BANKS - 1) begin
                                m_bank  = 0;
                                m_state = M_FINISH;
                            end else begin
                                m_bank++;
                            end
                        end else begin
                            m_addr++;
                        end
                    end
                end
                default: begin
                    m_state = M_IDLE;
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                end
            endcase
        end
        @(negedge CLK);
        cyc_n++;
        if (!rst_n) begin
            m_en     = 1'b0;
            m_we     = '0;
            m_addr_o = '0;
            m_di     = '0;
            m_known  = 1'b1;
        end else if (sb_q.size() > 0) begin
            w        = sb_q.pop_front();
            m_en     = 1'b1;
            m_we     = w.we;
            m_addr_o = w.addr;
            m_di     = w.di;
        end else begin
            m_en = 1'b0;
            m_we = '0;
        end
        n_checks++;
        if ({bus_if.BRAM_EN, bus_if.BRAM_WE, bus_if.BRAM_ADDR, bus_if.BRAM_DI} !== {m_en, m_we, m_addr_o, m_di}) begin
            n_fail++;
            $display("FAIL bram_write cyc=%0d got en=%b we=%h addr=%0d di=%h expected en=%b we=%h addr=%0d di=%h",
                     cyc_n, bus_if.BRAM_EN, bus_if.BRAM_WE, bus_if.BRAM_ADDR, bus_if.BRAM_DI,
                     m_en, m_we, m_addr_o, m_di);
        end
        n_checks++;
        if (BUSY !== m_busy) begin
            n_fail++;
            $display("FAIL busy cyc=%0d got %b expected %b", cyc_n, BUSY, m_busy);
        end
        n_checks++;
        if (DONE !== m_done) begin
            n_fail++;
            $display("FAIL done cyc=%0d got %b expected %b", cyc_n, DONE, m_done);
        end
        if (m_state == M_LOAD || !rst_n) begin
            n_checks++;
            if (BANK_IDX !== BANK_W'(m_bank)) begin
                n_fail++;
                $display("FAIL bank_idx cyc=%0d got %0d expected %0d", cyc_n, BANK_IDX, m_bank);
            end
        end
        if (bus_if.BRAM_WE !== '0) begin
            if (wr_count == 0) begin
                first_we   = bus_if.BRAM_WE;
                first_addr = bus_if.BRAM_ADDR;
            end
            if (wr_count == 785) begin
                w785_we   = bus_if.BRAM_WE;
                w785_addr = bus_if.BRAM_ADDR;
            end
            last_we   = bus_if.BRAM_WE;
            last_addr = bus_if.BRAM_ADDR;
            last_di   = bus_if.BRAM_DI;
            wr_count++;
        end
        if (DONE === 1'b1) begin
            done_count++;
            done_cyc = cyc_n;
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A);
        n_checks++;
        if ({bus_if.S_READY, bus_if.BRAM_EN, bus_if.BRAM_WE, bus_if.BRAM_ADDR, bus_if.BRAM_DI, BUSY, DONE, BANK_IDX} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b en=%b we=%h addr=%0d di=%h busy=%b done=%b bank=%0d expected all zero",
                     bus_if.S_READY, bus_if.BRAM_EN, bus_if.BRAM_WE, bus_if.BRAM_ADDR, bus_if.BRAM_DI, BUSY, DONE, BANK_IDX);
        end
    endtask

    task automatic test_idle_no_start();
        wr_count = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, DATA_W'($urandom_range(0, 255)));
        end
        n_checks++;
        if (wr_count != 0) begin
            n_fail++;
            $display("FAIL idle_writes got %0d expected 0", wr_count);
        end
    endtask

    // Full load; throttle=1 toggles S_VALID every other cycle
    task automatic test_full_load(input bit throttle);
        int guard;
        int start_cyc;
        wr_count   = 0;
        done_count = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        start_cyc = cyc_n;
        guard     = 0;
        while (m_state != M_IDLE && guard < 50000) begin
            step(1'b1, 1'b0, 1'b0, throttle ? 1'(guard & 1) : 1'b1, pattern(m_bank, m_addr));
            guard++;
        end
        n_checks++;
        if (m_state != M_IDLE) begin
            n_fail++;
            $display("FAIL load_timeout got %0d cycles expected completion", guard);
        end
        n_checks++;
        if (wr_count != TOTAL_WORDS) begin
            n_fail++;
            $display("FAIL write_count got %0d expected %0d", wr_count, TOTAL_WORDS);
        end
        n_checks++;
        if (first_we !== NUM_BANKS'(1) || first_addr !== '0) begin
            n_fail++;
            $display("FAIL first_write got we=%h addr=%0d expected we=1 addr=0", first_we, first_addr);
        end
        n_checks++;
        if (w785_we !== NUM_BANKS'(2) || w785_addr !== '0) begin
            n_fail++;
            $display("FAIL write_785 got we=%h addr=%0d expected we=2 addr=0", w785_we, w785_addr);
        end
        n_checks++;
        if (last_we !== 28'h8000000 || last_addr !== 11'd784 || last_di !== 8'h2B) begin
            n_fail++;
            $display("FAIL last_write got we=%h addr=%0d di=%h expected we=8000000 addr=784 di=2b",
                     last_we, last_addr, last_di);
        end
        n_checks++;
        if (done_count != 1) begin
            n_fail++;
            $display("FAIL done_pulses got %0d expected 1", done_count);
        end
        if (throttle) begin
            n_checks++;
            if (done_cyc - start_cyc < 43960 || done_cyc - start_cyc > 43964) begin
                n_fail++;
                $display("FAIL throttled_latency got %0d cycles expected about 43961", done_cyc - start_cyc);
            end
        end
    endtask

    task automatic check_restart(input string name);
        wr_count = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, pattern(m_bank, m_addr));
        end
        n_checks++;
        if (first_we !== NUM_BANKS'(1) || first_addr !== '0 || wr_count != 10) begin
            n_fail++;
            $display("FAIL %s restart got we=%h addr=%0d writes=%0d expected we=1 addr=0 writes=10",
                     name, first_we, first_addr, wr_count);
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hEE);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_abort();
        done_count = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, pattern(m_bank, m_addr));
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hC3);
        n_checks++;
        if (bus_if.BRAM_WE !== '0 || bus_if.BRAM_EN !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_cycle got we=%h en=%b busy=%b expected we=0 en=0 busy=0",
                     bus_if.BRAM_WE, bus_if.BRAM_EN, BUSY);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
        end
        n_checks++;
        if (done_count != 0) begin
            n_fail++;
            $display("FAIL abort_done got %0d pulses expected 0", done_count);
        end
        check_restart("abort");
    endtask

    task automatic test_reset_mid_load();
        done_count = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 499; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, pattern(m_bank, m_addr));
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, pattern(m_bank, m_addr));
        n_checks++;
        if ({bus_if.BRAM_EN, bus_if.BRAM_WE, bus_if.BRAM_ADDR, bus_if.BRAM_DI, BUSY, DONE, BANK_IDX} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got en=%b we=%h addr=%0d di=%h busy=%b done=%b bank=%0d expected all zero",
                     bus_if.BRAM_EN, bus_if.BRAM_WE, bus_if.BRAM_ADDR, bus_if.BRAM_DI, BUSY, DONE, BANK_IDX);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'h22);
        end
        n_checks++;
        if (done_count != 0) begin
            n_fail++;
            $display("FAIL midreset_done got %0d pulses expected 0", done_count);
        end
        check_restart("reset");
    endtask

    task automatic test_start_ignored();
        int guard;
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        guard = 0;
        while (!(m_bank == 3 && m_addr == 100) && guard < 5000) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, pattern(m_bank, m_addr));
            guard++;
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, pattern(m_bank, m_addr));
        n_checks++;
        if (bus_if.BRAM_WE !== NUM_BANKS'(8) || bus_if.BRAM_ADDR !== 11'd100 || BANK_IDX !== 5'd3 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignored got we=%h addr=%0d bank=%0d busy=%b expected we=8 addr=100 bank=3 busy=1",
                     bus_if.BRAM_WE, bus_if.BRAM_ADDR, BANK_IDX, BUSY);
        end
        guard = 0;
        while (m_bank != 4 && guard < 2000) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, pattern(m_bank, m_addr));
            guard++;
        end
        n_checks++;
        if (BANK_IDX !== 5'd4) begin
            n_fail++;
            $display("FAIL start_ignored_continue got bank=%0d expected 4", BANK_IDX);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        bus_if.S_VALID = 1'b0;
        bus_if.S_DATA  = '0;
        @(negedge CLK);
        test_reset();
        test_idle_no_start();
        test_full_load(1'b0);
        test_full_load(1'b1);
        test_abort();
        test_reset_mid_load();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
